approx_add_err_monitor: RTL and testbench

- Sits directly downstream of a 16-bit ripple-carry approximate adder under characterisation.
- Consumes each operand pair together with the approximate sum that adder produced.
- Computes the exact sum internally and accumulates error statistics over a programmed number of samples: error sum for MAE, maximum error, and count of erroneous samples.
- Reports the results with a one-cycle done pulse; feeds the delay/MAE evaluation flow.

---
 rtl/approx_eval_pkg.sv | 14 +
 rtl/abs_err_calc.sv | 19 +
 rtl/approx_add_err_monitor.sv | 132 +++++++++++++
 tb/tb_approx_add_err_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_eval_pkg.sv
// Shared FSM state encoding and default sizes for the approximate-adder error monitor.
package approx_eval_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/abs_err_calc.sv
// Exact sum of the adder operands and its absolute distance from the approximate sum.
// Purely combinational, no handshake.
module abs_err_calc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx,
  output logic [WIDTH:0]   e,
  output logic             nz
);

  logic [WIDTH:0] exact;

  assign exact = {1'b0, a} + {1'b0, b};
  assign e     = (exact >= approx) ? (exact - approx) : (approx - exact);
  assign nz    = (e != '0);

endmodule

// File: rtl/approx_add_err_monitor.sv
// Accumulates |exact-approx| statistics over a programmed run of adder samples.
// Stats trail a transfer by two edges; in_ready drops once the run count is accepted.
module approx_add_err_monitor
  import approx_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH:0]     in_approx,
  output logic               busy,
  output logic               done,
  output logic [WIDTH+CNT_W:0] err_sum,
  output logic [WIDTH:0]     max_err,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state;
  logic [CNT_W-1:0] n_samp;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] acc_inc;
  logic             xfer;
  logic             clr_stats;

  logic [WIDTH:0]   calc_e;
  logic             calc_nz;

  logic             s1_vld;
  logic [WIDTH:0]   s1_e;
  logic             s1_nz;

  assign xfer      = in_valid && in_ready;
  assign clr_stats = (state == IDLE) && start;
  assign acc_inc   = acc_cnt + CNT_ONE;

  abs_err_calc #(
    .WIDTH (WIDTH)
  ) u_abs_err_calc (
    .a      (in_a),
    .b      (in_b),
    .approx (in_approx),
    .e      (calc_e),
    .nz     (calc_nz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_samp   <= '0;
      acc_cnt  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_samp  <= num_samples;
            acc_cnt <= '0;
            busy    <= 1'b1;
            if (num_samples == '0) begin
              state <= DONE;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            acc_cnt <= acc_inc;
            if (acc_inc == n_samp) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        // Stage 1 cannot refill here, so its last sample lands in stage 2 on this edge.
        DRAIN: begin
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_e    <= '0;
      s1_nz   <= 1'b0;
      err_sum <= '0;
      max_err <= '0;
      err_cnt <= '0;
    end else begin
      s1_vld <= xfer;
      if (xfer) begin
        s1_e  <= calc_e;
        s1_nz <= calc_nz;
      end
      if (clr_stats) begin
        err_sum <= '0;
        max_err <= '0;
        err_cnt <= '0;
      end else if (s1_vld) begin
        err_sum <= err_sum + {{CNT_W{1'b0}}, s1_e};
        if (s1_e > max_err) begin
          max_err <= s1_e;
        end
        err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, s1_nz};
      end
    end
  end

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Directed bench for approx_add_err_monitor with hand-computed error statistics.
module tb_approx_add_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [16:0] in_approx;
  logic        busy;
  logic        done;
  logic [32:0] err_sum;
  logic [16:0] max_err;
  logic [15:0] err_cnt;

  int total = 0;
  int bad   = 0;

  approx_add_err_monitor #(
    .WIDTH (16),
    .CNT_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_approx   (in_approx),
    .busy        (busy),
    .done        (done),
    .err_sum     (err_sum),
    .max_err     (max_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and hold it until the edge that accepts it (bounded).
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [16:0] ap);
    int n;
    in_a      = a;
    in_b      = b;
    in_approx = ap;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < lim) begin
      tick();
      cyc++;
    end
  endtask

  task automatic kick(input logic [15:0] n);
    num_samples = n;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0)     $display("FAIL reset_busy got=%0b exp=0", busy);
    if (busy !== 1'b0) bad++;
    total++; if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready got=%0b exp=0", in_ready); bad++; end
    total++; if (done !== 1'b0)     begin $display("FAIL reset_done got=%0b exp=0", done); bad++; end
    total++; if (err_sum !== 33'd0) begin $display("FAIL reset_err_sum got=%0h exp=0", err_sum); bad++; end
    total++; if (max_err !== 17'd0) begin $display("FAIL reset_max_err got=%0h exp=0", max_err); bad++; end
    total++; if (err_cnt !== 16'd0) begin $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); bad++; end
  endtask

  task automatic test_basic();
    int cyc;
    kick(16'd3);
    total++; if (busy !== 1'b1)     begin $display("FAIL basic_busy got=%0b exp=1", busy); bad++; end
    total++; if (in_ready !== 1'b1) begin $display("FAIL basic_in_ready got=%0b exp=1", in_ready); bad++; end
    send(16'd1, 16'd1, 17'd2);
    send(16'd63, 16'd1, 17'd63);
    send(16'h8000, 16'h8000, 17'h10000);
    wait_done(10, cyc);
    total++; if (cyc != 2)          begin $display("FAIL basic_done_lat got=%0d exp=2", cyc); bad++; end
    total++; if (err_sum !== 33'd1) begin $display("FAIL basic_err_sum got=%0h exp=1", err_sum); bad++; end
    total++; if (max_err !== 17'd1) begin $display("FAIL basic_max_err got=%0h exp=1", max_err); bad++; end
    total++; if (err_cnt !== 16'd1) begin $display("FAIL basic_err_cnt got=%0d exp=1", err_cnt); bad++; end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL basic_pulse got done=%0b busy=%0b exp 0 0", done, busy); bad++;
    end
  endtask

  task automatic test_zero();
    int cyc;
    kick(16'd0);
    total++; if (busy !== 1'b1) begin $display("FAIL zero_busy got=%0b exp=1", busy); bad++; end
    wait_done(8, cyc);
    total++; if (cyc != 1)      begin $display("FAIL zero_done_lat got=%0d exp=1", cyc); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL zero_busy_fall got=%0b exp=0", busy); bad++; end
    total++; if (err_sum !== 33'd0 || max_err !== 17'd0 || err_cnt !== 16'd0) begin
      $display("FAIL zero_stats got sum=%0h max=%0h cnt=%0d exp 0 0 0", err_sum, max_err, err_cnt); bad++;
    end
    tick();
    total++; if (done !== 1'b0) begin $display("FAIL zero_pulse got=%0b exp=0", done); bad++; end
  endtask

  task automatic test_abs();
    int cyc;
    kick(16'd2);
    send(16'hFFFF, 16'hFFFF, 17'h00000);
    send(16'd5, 16'd3, 17'h1FFFF);
    wait_done(10, cyc);
    total++; if (cyc != 2)              begin $display("FAIL abs_done_lat got=%0d exp=2", cyc); bad++; end
    total++; if (err_sum !== 33'h3FFF5) begin $display("FAIL abs_err_sum got=%0h exp=3fff5", err_sum); bad++; end
    total++; if (max_err !== 17'h1FFFE) begin $display("FAIL abs_max_err got=%0h exp=1fffe", max_err); bad++; end
    total++; if (err_cnt !== 16'd2)     begin $display("FAIL abs_err_cnt got=%0d exp=2", err_cnt); bad++; end
  endtask

  task automatic test_gaps();
    bit [5:0] vp;
    int nx;
    vp = 6'b101101;  // bit i = in_valid in offered cycle i
    nx = 0;
    kick(16'd4);
    for (int i = 0; i < 6; i++) begin
      in_valid = vp[i];
      case (i)
        0:       begin in_a = 16'd10; in_b = 16'd0; in_approx = 17'd11; end
        2:       begin in_a = 16'd10; in_b = 16'd0; in_approx = 17'd8;  end
        3:       begin in_a = 16'd0;  in_b = 16'd0; in_approx = 17'd3;  end
        5:       begin in_a = 16'd1;  in_b = 16'd1; in_approx = 17'd6;  end
        default: begin in_a = 16'd0;  in_b = 16'd0; in_approx = 17'h1FFFF; end
      endcase
      if (in_valid && in_ready) nx++;
      tick();
    end
    in_valid  = 1'b1;
    in_a      = 16'd0;
    in_b      = 16'd0;
    in_approx = 17'h1FFFF;
    total++; if (in_ready !== 1'b0) begin $display("FAIL gaps_refuse got in_ready=%0b exp=0", in_ready); bad++; end
    if (in_valid && in_ready) nx++;
    tick();
    in_valid = 1'b0;
    total++; if (done !== 1'b0)     begin $display("FAIL gaps_done_early got=%0b exp=0", done); bad++; end
    tick();
    total++; if (done !== 1'b1)     begin $display("FAIL gaps_done_lat got=%0b exp=1", done); bad++; end
    total++; if (nx != 4)           begin $display("FAIL gaps_xfers got=%0d exp=4", nx); bad++; end
    total++; if (err_sum !== 33'd10) begin $display("FAIL gaps_err_sum got=%0h exp=a", err_sum); bad++; end
    total++; if (max_err !== 17'd4)  begin $display("FAIL gaps_max_err got=%0h exp=4", max_err); bad++; end
    total++; if (err_cnt !== 16'd4)  begin $display("FAIL gaps_err_cnt got=%0d exp=4", err_cnt); bad++; end
  endtask

  task automatic test_start_ignored();
    kick(16'd2);
    start       = 1'b1;
    num_samples = 16'd5;
    send(16'd100, 16'd200, 17'd290);
    start = 1'b0;
    send(16'd7, 16'd7, 17'd14);
    start       = 1'b1;
    num_samples = 16'd7;
    tick();
    tick();
    total++; if (done !== 1'b1) begin $display("FAIL ign_done got=%0b exp=1", done); bad++; end
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL ign_idle got busy=%0b in_ready=%0b exp 0 0", busy, in_ready); bad++;
    end
    total++; if (err_sum !== 33'd10 || max_err !== 17'd10 || err_cnt !== 16'd1) begin
      $display("FAIL ign_stats got sum=%0h max=%0h cnt=%0d exp a a 1", err_sum, max_err, err_cnt); bad++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    kick(16'd10);
    for (int i = 0; i < 3; i++) send(16'd1, 16'd2, 17'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0)     begin $display("FAIL rmid_busy got=%0b exp=0", busy); bad++; end
    total++; if (in_ready !== 1'b0) begin $display("FAIL rmid_in_ready got=%0b exp=0", in_ready); bad++; end
    total++; if (err_sum !== 33'd0 || max_err !== 17'd0 || err_cnt !== 16'd0) begin
      $display("FAIL rmid_stats got sum=%0h max=%0h cnt=%0d exp 0 0 0", err_sum, max_err, err_cnt); bad++;
    end
    seen = (done === 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    total++; if (seen) begin $display("FAIL rmid_no_done got done pulse exp none"); bad++; end
    kick(16'd1);
    send(16'd2, 16'd2, 17'd5);
    wait_done(10, cyc);
    total++; if (cyc != 2) begin $display("FAIL rmid_rerun_lat got=%0d exp=2", cyc); bad++; end
    total++; if (err_sum !== 33'd1 || max_err !== 17'd1 || err_cnt !== 16'd1) begin
      $display("FAIL rmid_rerun_stats got sum=%0h max=%0h cnt=%0d exp 1 1 1", err_sum, max_err, err_cnt); bad++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_samples = 16'd0;
    in_valid    = 1'b0;
    in_a        = 16'd0;
    in_b        = 16'd0;
    in_approx   = 17'd0;
    test_reset();
    test_basic();
    test_zero();
    test_abs();
    test_gaps();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
